// File: rtl/risc_pkg.sv
// Shared constants and types for the program/data memory bus.
package risc_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 5;

    typedef logic port_id_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                  sel;
        logic                  rd;
        logic                  wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/arb_rr_pick.sv
// Two-way round-robin picker.
// A locked state restricts the pick to its owner.
module arb_rr_pick
    import risc_pkg::*;
(
    input  logic [1:0] req,
    input  port_id_t   rr_last,
    input  arb_state_t state,
    output logic [1:0] gnt,
    output port_id_t   gnt_id
);

    always_comb begin
        gnt    = 2'b00;
        gnt_id = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (req == 2'b11) gnt_id = ~rr_last;
                else              gnt_id = req[1];
                if (req != 2'b00) gnt = gnt_id ? 2'b10 : 2'b01;
            end
            ARB_OWN0: begin
                if (req[0]) gnt = 2'b01;
            end
            ARB_OWN1: begin
                if (req[1]) begin
                    gnt    = 2'b10;
                    gnt_id = 1'b1;
                end
            end
            default: begin
                gnt    = 2'b00;
                gnt_id = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbiter sharing the 32x8 program/data memory between the CPU (port 0) and loader (port 1).
// state    | meaning
// ARB_IDLE | round-robin between requesters, no lock held
// ARB_OWN0 | port 0 holds the bus lock, port 1 waits
// ARB_OWN1 | port 1 holds the bus lock, port 0 waits
module mem_bus_arbiter #(
    parameter int DATA_WIDTH = risc_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = risc_pkg::ADDR_WIDTH,
    parameter int LOCK_MAX   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req,
    input  logic [1:0]            lock,
    input  logic [1:0]            we,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic [1:0]            gnt,
    output logic [1:0]            rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            owner,
    output logic                  mem_sel,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    import risc_pkg::*;

    localparam logic [3:0] LOCK_CNT_MAX = 4'(LOCK_MAX);

    arb_state_t state, state_nxt;
    port_id_t   rr_last, rr_nxt, pick_id, own_id, rd_port;
    logic [1:0] pick_gnt;
    logic [3:0] lock_cnt, cnt_nxt, cnt_inc;
    logic       any_gnt, pick_we, pick_lock, rd_valid;
    mem_cmd_t   cmd;

    arb_rr_pick u_pick (
        .req     (req),
        .rr_last (rr_last),
        .state   (state),
        .gnt     (pick_gnt),
        .gnt_id  (pick_id)
    );

    // Grants are blocked while reset is held so nothing reaches the memory.
    assign gnt       = rst ? pick_gnt : 2'b00;
    assign any_gnt   = |gnt;
    assign pick_we   = pick_id ? we[1] : we[0];
    assign pick_lock = pick_id ? lock[1] : lock[0];
    assign own_id    = (state == ARB_OWN1);
    assign cnt_inc   = lock_cnt + 4'd1;

    always_comb begin
        cmd = '0;
        if (any_gnt) begin
            cmd.sel   = 1'b1;
            cmd.rd    = ~pick_we;
            cmd.wr    = pick_we;
            cmd.addr  = pick_id ? addr1 : addr0;
            cmd.wdata = pick_id ? wdata1 : wdata0;
        end
    end

    assign mem_sel   = cmd.sel;
    assign mem_rd    = cmd.rd;
    assign mem_wr    = cmd.wr;
    assign mem_addr  = cmd.addr;
    assign mem_wdata = cmd.wdata;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = lock_cnt;
        rr_nxt    = rr_last;
        case (state)
            ARB_IDLE: begin
                if (any_gnt) begin
                    rr_nxt = pick_id;
                    // With LOCK_MAX == 1 the opening grant already exhausts the lock.
                    if (pick_lock && (LOCK_MAX > 1)) begin
                        state_nxt = pick_id ? ARB_OWN1 : ARB_OWN0;
                        cnt_nxt   = 4'd1;
                    end
                end
            end
            ARB_OWN0, ARB_OWN1: begin
                if (!any_gnt || !pick_lock || (cnt_inc == LOCK_CNT_MAX)) begin
                    state_nxt = ARB_IDLE;
                    cnt_nxt   = 4'd0;
                    rr_nxt    = own_id;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ARB_IDLE;
            rr_last  <= 1'b1;
            lock_cnt <= 4'd0;
            rd_valid <= 1'b0;
            rd_port  <= 1'b0;
        end else begin
            state    <= state_nxt;
            rr_last  <= rr_nxt;
            lock_cnt <= cnt_nxt;
            rd_valid <= any_gnt & ~pick_we;
            rd_port  <= pick_id;
        end
    end

    always_comb begin
        case (state)
            ARB_OWN0: owner = 2'b01;
            ARB_OWN1: owner = 2'b10;
            default:  owner = 2'b00;
        endcase
    end

    assign rvalid = rd_valid ? (rd_port ? 2'b10 : 2'b01) : 2'b00;
    assign rdata  = rd_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios followed by random traffic
// against a cycle-level reference model and a simple memory responder.
module tb_mem_bus_arbiter;

    localparam int LOCK_MAX = 4;

    logic       clk;
    logic       rst;
    logic [1:0] req, lock, we;
    logic [4:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic [1:0] gnt, rvalid, owner;
    logic [7:0] rdata;
    logic       mem_sel, mem_rd, mem_wr;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;

    mem_bus_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .LOCK_MAX(LOCK_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .lock      (lock),
        .we        (we),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .owner     (owner),
        .mem_sel   (mem_sel),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory responder: read data one cycle after mem_rd
    logic [7:0] tb_mem [32];
    always @(posedge clk) begin
        if (mem_wr) tb_mem[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= tb_mem[mem_addr];
    end

    int n_checks = 0;
    int n_err    = 0;

    // reference model state
    int         m_owner = -1;
    int         m_cnt   = 0;
    int         m_last  = 1;
    bit         m_rv    = 1'b0;
    int         m_rport = 0;
    logic [7:0] m_rexp  = 8'h00;
    logic [7:0] m_mem [32];
    int         wait_cnt [2] = '{0, 0};
    int         last_p  = -1;

    logic [1:0] obs_gnt, obs_owner, obs_rv;
    logic [7:0] obs_rdata;
    logic       obs_rd;
    logic [4:0] obs_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic [1:0] rq, input logic [1:0] lk,
                       input logic [1:0] w, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1);
        int         p;
        logic [4:0] pa;
        logic [7:0] pd;
        logic       e_we, e_lk;
        logic [1:0] e_gnt, e_owner, e_rv;
        logic [7:0] e_rdata;
        @(negedge clk);
        rst = r; req = rq; lock = lk; we = w;
        addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
        #1;
        if (!r) begin
            m_owner = -1; m_cnt = 0; m_last = 1; m_rv = 1'b0;
        end
        p = -1;
        if (r) begin
            if (m_owner < 0) begin
                if (rq == 2'b11)      p = 1 - m_last;
                else if (rq == 2'b01) p = 0;
                else if (rq == 2'b10) p = 1;
            end else if (rq[m_owner]) begin
                p = m_owner;
            end
        end
        pa      = (p == 1) ? a1 : a0;
        pd      = (p == 1) ? d1 : d0;
        e_we    = (p < 0) ? 1'b0 : ((p == 1) ? w[1] : w[0]);
        e_lk    = (p == 1) ? lk[1] : lk[0];
        e_gnt   = (p < 0) ? 2'b00 : ((p == 1) ? 2'b10 : 2'b01);
        e_owner = (m_owner < 0) ? 2'b00 : ((m_owner == 1) ? 2'b10 : 2'b01);
        e_rv    = m_rv ? ((m_rport == 1) ? 2'b10 : 2'b01) : 2'b00;
        e_rdata = m_rv ? m_rexp : 8'h00;

        chk("gnt",       32'(gnt),       32'(e_gnt));
        chk("mem_sel",   32'(mem_sel),   32'(p >= 0));
        chk("mem_rd",    32'(mem_rd),    32'((p >= 0) && !e_we));
        chk("mem_wr",    32'(mem_wr),    32'((p >= 0) && e_we));
        chk("mem_addr",  32'(mem_addr),  32'((p >= 0) ? pa : 5'd0));
        chk("mem_wdata", 32'(mem_wdata), 32'((p >= 0) ? pd : 8'd0));
        chk("owner",     32'(owner),     32'(e_owner));
        chk("rvalid",    32'(rvalid),    32'(e_rv));
        chk("rdata",     32'(rdata),     32'(e_rdata));
        obs_gnt = gnt; obs_owner = owner; obs_rv = rvalid; obs_rdata = rdata;
        obs_rd = mem_rd; obs_addr = mem_addr;

        for (int i = 0; i < 2; i++) begin
            if (!r) wait_cnt[i] = 0;
            else if (rq[i]) begin
                if (p == i) wait_cnt[i] = 0;
                else begin
                    wait_cnt[i]++;
                    chk("starvation_bound", 32'(wait_cnt[i] <= LOCK_MAX), 32'd1);
                end
            end
        end

        m_rv = (p >= 0) && !e_we;
        if (m_rv) begin
            m_rport = p;
            m_rexp  = m_mem[pa];
        end
        if ((p >= 0) && e_we) m_mem[pa] = pd;
        if (m_owner < 0) begin
            if (p >= 0) begin
                m_last = p;
                if (e_lk && (LOCK_MAX > 1)) begin
                    m_owner = p;
                    m_cnt   = 1;
                end
            end
        end else if ((p < 0) || !e_lk || (m_cnt + 1 >= LOCK_MAX)) begin
            m_last  = m_owner;
            m_owner = -1;
            m_cnt   = 0;
        end else begin
            m_cnt++;
        end
        last_p = p;
    endtask

    initial begin
        logic [1:0] rq;
        rst = 1'b0; req = 2'b00; lock = 2'b00; we = 2'b00;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

        // reset held with both requesting
        cyc(1'b0, 2'b11, 2'b00, 2'b11, 5'h00, 5'h01, 8'h11, 8'h22);
        chk("reset_gnt", 32'(obs_gnt), 32'd0);
        cyc(1'b0, 2'b11, 2'b00, 2'b11, 5'h00, 5'h01, 8'h11, 8'h22);
        chk("reset_owner", 32'(obs_owner), 32'd0);
        cyc(1'b1, 2'b11, 2'b00, 2'b11, 5'h00, 5'h01, 8'h11, 8'h22);
        chk("first_gnt", 32'(obs_gnt), 32'h1);
        cyc(1'b1, 2'b11, 2'b00, 2'b11, 5'h00, 5'h01, 8'h11, 8'h22);
        chk("second_gnt", 32'(obs_gnt), 32'h2);

        // preload every word through port 1
        for (int i = 0; i < 32; i++)
            cyc(1'b1, 2'b10, 2'b00, 2'b10, 5'h00, 5'(i), 8'h00,
                (i == 10) ? 8'h3C : 8'(i * 37 + 5));

        // single read by port 1
        cyc(1'b1, 2'b10, 2'b00, 2'b00, 5'h00, 5'h0A, 8'h00, 8'h00);
        chk("read_gnt", 32'(obs_gnt), 32'h2);
        chk("read_mem_rd", 32'(obs_rd), 32'd1);
        chk("read_mem_addr", 32'(obs_addr), 32'h0A);
        cyc(1'b1, 2'b00, 2'b00, 2'b00, 5'h00, 5'h00, 8'h00, 8'h00);
        chk("read_rvalid", 32'(obs_rv), 32'h2);
        chk("read_rdata", 32'(obs_rdata), 32'h3C);

        // continuous contention alternates
        for (int k = 0; k < 6; k++) begin
            cyc(1'b1, 2'b11, 2'b00, 2'b01, 5'h01, 5'h02, 8'h55, 8'h00);
            chk("contention_gnt", 32'(obs_gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
        end

        // port 0 lock runs to LOCK_MAX grants, then port 1
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, (k == 4) ? 2'b10 : 2'b11, 2'b01, 2'b00, 5'(k), 5'h02, 8'h00, 8'h00);
            chk("lock_gnt", 32'(obs_gnt), (k < 4) ? 32'h1 : 32'h2);
            chk("lock_owner", 32'(obs_owner), (k == 0 || k == 4) ? 32'h0 : 32'h1);
        end

        // early unlock: locked read then unlocked write
        cyc(1'b1, 2'b11, 2'b01, 2'b00, 5'h03, 5'h04, 8'h00, 8'h00);
        chk("unlock_gnt0", 32'(obs_gnt), 32'h1);
        cyc(1'b1, 2'b11, 2'b00, 2'b01, 5'h03, 5'h04, 8'hA5, 8'h00);
        chk("unlock_gnt1", 32'(obs_gnt), 32'h1);
        chk("unlock_owner", 32'(obs_owner), 32'h1);
        cyc(1'b1, 2'b10, 2'b00, 2'b00, 5'h03, 5'h04, 8'h00, 8'h00);
        chk("unlock_gnt2", 32'(obs_gnt), 32'h2);
        chk("unlock_owner_clr", 32'(obs_owner), 32'h0);

        // reset in the cycle after a read grant
        cyc(1'b1, 2'b01, 2'b00, 2'b00, 5'h03, 5'h00, 8'h00, 8'h00);
        chk("rstrd_gnt", 32'(obs_gnt), 32'h1);
        cyc(1'b0, 2'b11, 2'b11, 2'b00, 5'h03, 5'h04, 8'h00, 8'h00);
        chk("rstrd_rvalid", 32'(obs_rv), 32'h0);
        chk("rstrd_rdata", 32'(obs_rdata), 32'h0);
        cyc(1'b1, 2'b00, 2'b00, 2'b00, 5'h00, 5'h00, 8'h00, 8'h00);
        chk("rstrd_after", 32'(obs_rv), 32'h0);

        // random traffic; requests are held until granted
        rq = 2'b00;
        for (int k = 0; k < 3000; k++) begin
            logic [1:0] nrq;
            logic       r;
            for (int i = 0; i < 2; i++)
                nrq[i] = (rq[i] && (last_p != i)) ? 1'b1 : ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 499) != 0);
            cyc(r, nrq, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                5'($urandom), 5'($urandom), 8'($urandom), 8'($urandom));
            rq = nrq;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
